// File: rtl/frame_strobe_ctrl_pkg.sv
// rtl/frame_strobe_ctrl_pkg.sv - shared states, header marker and header field positions
package frame_strobe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2
    } state_t;

    localparam logic [7:0] HDR_MARKER   = 8'hFA;
    localparam int         HDR_MARK_LSB = 24;
    localparam int         HDR_MARK_W   = 8;
    localparam int         HDR_COL_LSB  = 16;
    localparam int         HDR_COL_W    = 8;
    localparam int         HDR_IDX_LSB  = 0;
    localparam int         HDR_IDX_W    = 5;

endpackage

// File: rtl/frame_strobe_ctrl_if.sv
// rtl/frame_strobe_ctrl_if.sv - configuration word stream with valid/ready handshake
interface frame_strobe_ctrl_if #(
    parameter int FrameBitsPerRow = 32
) ();
    logic [FrameBitsPerRow-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/frame_strobe_dec.sv
// rtl/frame_strobe_dec.sv - registered frame index to one-hot strobe decoder
module frame_strobe_dec
    import frame_strobe_ctrl_pkg::*;
#(
    parameter int MaxFramesPerCol = 20
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       i_en,
    input  logic [HDR_IDX_W-1:0]       i_idx,
    output logic [MaxFramesPerCol-1:0] o_strobe
);

    logic [MaxFramesPerCol-1:0] w_onehot;
    logic [MaxFramesPerCol-1:0] r_strobe;

    // Compare against each position so an index outside the range simply yields zero.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            w_onehot[i] = i_en && (i_idx == HDR_IDX_W'(i));
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_strobe <= '0;
        end else begin
            r_strobe <= w_onehot;
        end
    end

    assign o_strobe = r_strobe;

endmodule

// File: rtl/frame_strobe_ctrl.sv
// rtl/frame_strobe_ctrl.sv - column frame loader: header, NumRows data words, one-cycle frame strobe
module frame_strobe_ctrl
    import frame_strobe_ctrl_pkg::*;
#(
    parameter int         MaxFramesPerCol = 20,
    parameter int         FrameBitsPerRow = 32,
    parameter int         NumRows         = 4,
    parameter logic [7:0] ColumnID        = 8'd0
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    frame_strobe_ctrl_if.slave                   bus,
    output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 hdr_err,
    output logic [15:0]                          frame_cnt
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int FrameW = FrameBitsPerRow * NumRows;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_match;
    logic [HDR_IDX_W-1:0]   r_frame_idx;
    logic [RowW-1:0]        r_row;
    logic [FrameW-1:0]      r_shadow;
    logic [FrameW-1:0]      r_frame_data;
    logic [15:0]            r_frame_cnt;
    logic                   r_hdr_err;

    logic                   w_accept;
    logic [HDR_MARK_W-1:0]  w_hdr_mark;
    logic [HDR_COL_W-1:0]   w_hdr_col;
    logic [HDR_IDX_W-1:0]   w_hdr_idx;
    logic                   w_hdr_ok;
    logic                   w_last_row;
    logic                   w_hdr_load;
    logic                   w_hdr_bad;
    logic                   w_row_wr;
    logic                   w_commit;
    logic                   w_cnt_inc;
    logic [FrameW-1:0]      w_frame_next;

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_hdr_mark = bus.in_data[HDR_MARK_LSB +: HDR_MARK_W];
    assign w_hdr_col  = bus.in_data[HDR_COL_LSB +: HDR_COL_W];
    assign w_hdr_idx  = bus.in_data[HDR_IDX_LSB +: HDR_IDX_W];
    assign w_hdr_ok   = (w_hdr_mark == HDR_MARKER) && (int'(w_hdr_idx) < MaxFramesPerCol);
    assign w_last_row = (r_row == RowW'(NumRows - 1));

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_load  = 1'b0;
        w_hdr_bad   = 1'b0;
        w_row_wr    = 1'b0;
        w_commit    = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_hdr_ok) begin
                        w_hdr_load  = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_hdr_bad   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_row_wr = 1'b1;
                    if (w_last_row) begin
                        w_commit    = r_match;
                        w_state_nxt = r_match ? ST_STROBE : ST_IDLE;
                    end
                end
            end
            ST_STROBE: begin
                w_cnt_inc   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The completed frame is the shadow with the word now being accepted merged into its row.
    always_comb begin
        w_frame_next = r_shadow;
        w_frame_next[int'(r_row)*FrameBitsPerRow +: FrameBitsPerRow] = bus.in_data;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_match      <= 1'b0;
            r_frame_idx  <= '0;
            r_row        <= '0;
            r_shadow     <= '0;
            r_frame_data <= '0;
            r_frame_cnt  <= '0;
            r_hdr_err    <= 1'b0;
        end else begin
            if (w_hdr_load) begin
                r_match     <= (w_hdr_col == ColumnID);
                r_frame_idx <= w_hdr_idx;
                r_row       <= '0;
            end
            if (w_hdr_bad) begin
                r_hdr_err <= 1'b1;
            end
            if (w_row_wr) begin
                r_shadow <= w_frame_next;
                r_row    <= w_last_row ? '0 : r_row + RowW'(1);
            end
            if (w_commit) begin
                r_frame_data <= w_frame_next;
            end
            if (w_cnt_inc) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Decoder registers on the commit edge so the strobe lands in the STROBE cycle.
    frame_strobe_dec #(
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_dec (
        .CLK      (CLK),
        .resetn   (resetn),
        .i_en     (w_commit),
        .i_idx    (r_frame_idx),
        .o_strobe (FrameStrobe)
    );

    assign bus.in_ready = (r_state != ST_STROBE);
    assign busy         = (r_state != ST_IDLE);
    assign FrameData    = r_frame_data;
    assign hdr_err      = r_hdr_err;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
// tb/tb_frame_strobe_ctrl.sv - directed scoreboard bench for frame_strobe_ctrl
module tb_frame_strobe_ctrl;

    localparam int FB = 32;
    localparam int NR = 4;
    localparam int MF = 20;

    logic CLK = 1'b0;
    logic resetn;
    always #5 CLK = ~CLK;

    frame_strobe_ctrl_if #(.FrameBitsPerRow(FB)) bus ();

    logic [FB*NR-1:0] FrameData;
    logic [MF-1:0]    FrameStrobe;
    logic             busy;
    logic             hdr_err;
    logic [15:0]      frame_cnt;

    frame_strobe_ctrl #(
        .MaxFramesPerCol (MF),
        .FrameBitsPerRow (FB),
        .NumRows         (NR),
        .ColumnID        (8'd0)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .bus         (bus),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .hdr_err     (hdr_err),
        .frame_cnt   (frame_cnt)
    );

    typedef struct packed {
        logic [127:0] data;
        logic [19:0]  strobe;
    } exp_t;

    exp_t         sb_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [15:0]  exp_cnt;
    logic [127:0] last_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        if (resetn === 1'b1 && FrameStrobe !== '0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_strobe", 128'(FrameStrobe), 128'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_strobe", 128'(FrameStrobe), 128'(e.strobe));
                chk("sb_data", FrameData, e.data);
            end
        end
    end

    task automatic send(input logic [31:0] d, output int waits);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        waits = 0;
        while (bus.in_ready !== 1'b1 && waits < 20) begin
            @(posedge CLK);
            #1;
            waits++;
        end
        if (waits >= 20) chk("send_timeout", 128'(waits), 128'd0);
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_frame(input logic [31:0] hdr, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input int gap,
                             input bit skip_hdr);
        logic [31:0] w [4];
        int          n;
        bit          match;
        logic [19:0] es;
        exp_t        e;
        w     = '{w0, w1, w2, w3};
        match = (hdr[23:16] == 8'd0);
        es    = 20'd1 << hdr[4:0];
        if (!skip_hdr) send(hdr, n);
        for (int i = 0; i < 4; i++) begin
            if (gap > 0 && i > 0) begin
                idle(gap);
                chk("stall_busy", 128'(busy), 128'd1);
                chk("stall_no_strobe", 128'(FrameStrobe), 128'd0);
            end
            if (i == 3 && match) begin
                e.data   = {w3, w2, w1, w0};
                e.strobe = es;
                sb_q.push_back(e);
            end
            send(w[i], n);
        end
        if (match) begin
            chk("latency_strobe", 128'(FrameStrobe), 128'(es));
            chk("strobe_in_ready", 128'(bus.in_ready), 128'd0);
            exp_cnt   = exp_cnt + 16'd1;
            last_data = {w3, w2, w1, w0};
        end else begin
            chk("nomatch_no_strobe", 128'(FrameStrobe), 128'd0);
        end
    endtask

    task automatic post_checks();
        chk("post_strobe_clear", 128'(FrameStrobe), 128'd0);
        chk("post_frame_cnt", 128'(frame_cnt), 128'(exp_cnt));
        chk("post_busy", 128'(busy), 128'd0);
        chk("post_frame_data", FrameData, last_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn       = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        exp_cnt      = 16'd0;
        last_data    = '0;

        #1 resetn = 1'b0;
        #2;
        chk("rst_strobe", 128'(FrameStrobe), 128'd0);
        chk("rst_data", FrameData, 128'd0);
        chk("rst_cnt", 128'(frame_cnt), 128'd0);
        chk("rst_hdr_err", 128'(hdr_err), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1 resetn = 1'b1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);

        run_frame(32'hFA00_0003, 32'd1, 32'd2, 32'd3, 32'd4, 0, 1'b0);
        idle(1);
        post_checks();
        chk("basic_data_const", FrameData, 128'h00000004_00000003_00000002_00000001);
        chk("basic_cnt_const", 128'(frame_cnt), 128'd1);

        run_frame(32'hFA05_0003, 32'd5, 32'd6, 32'd7, 32'd8, 0, 1'b0);
        idle(2);
        post_checks();

        send(32'hAB00_0001, n);
        chk("bad_marker_err", 128'(hdr_err), 128'd1);
        chk("bad_marker_idle", 128'(busy), 128'd0);
        send(32'hFA00_0014, n);
        chk("bad_index_idle", 128'(busy), 128'd0);
        chk("bad_index_err", 128'(hdr_err), 128'd1);
        run_frame(32'hFA00_0007, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 0, 1'b0);
        idle(1);
        post_checks();
        chk("hdr_err_sticky", 128'(hdr_err), 128'd1);

        run_frame(32'hFA00_000A, 32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'hA3A3_A3A3, 2, 1'b0);
        send(32'hFA00_0002, n);
        chk("held_hdr_wait", 128'(n), 128'd1);
        chk("held_hdr_load", 128'(busy), 128'd1);
        run_frame(32'hFA00_0002, 32'hB0B0_0000, 32'hB1B1_0001, 32'hB2B2_0002, 32'hB3B3_0003, 1, 1'b1);
        idle(1);
        post_checks();

        send(32'hFA00_0005, n);
        send(32'hC0C0_C0C0, n);
        send(32'hC1C1_C1C1, n);
        resetn = 1'b0;
        #1;
        chk("abort_strobe", 128'(FrameStrobe), 128'd0);
        chk("abort_data", FrameData, 128'd0);
        chk("abort_cnt", 128'(frame_cnt), 128'd0);
        chk("abort_hdr_err", 128'(hdr_err), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        exp_cnt   = 16'd0;
        last_data = '0;
        @(posedge CLK);
        #1 resetn = 1'b1;
        chk("abort_in_ready", 128'(bus.in_ready), 128'd1);
        idle(3);
        chk("abort_no_strobe", 128'(FrameStrobe), 128'd0);
        run_frame(32'hFA00_0001, 32'hD0D0_0000, 32'hD1D1_0000, 32'hD2D2_0000, 32'hD3D3_0000, 0, 1'b0);
        idle(1);
        post_checks();

        force dut.r_frame_cnt = 16'hFFFF;
        @(posedge CLK);
        #1;
        release dut.r_frame_cnt;
        exp_cnt = 16'hFFFF;
        chk("wrap_preload", 128'(frame_cnt), 128'hFFFF);
        run_frame(32'hFA00_0013, 32'hE0E0_E0E0, 32'hE1E1_E1E1, 32'hE2E2_E2E2, 32'hE3E3_E3E3, 0, 1'b0);
        chk("idx19_strobe", 128'(FrameStrobe), 128'h80000);
        idle(1);
        post_checks();
        chk("wrap_cnt_zero", 128'(frame_cnt), 128'd0);

        idle(2);
        chk("sb_empty", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_strobe_ctrl.md
FRAME_STROBE_CTRL -- requirements
Module: frame_strobe_ctrl

Interface
REQ-001 Parameters SHALL be: MaxFramesPerCol, default 20, number of frame strobes per column; FrameBitsPerRow, default 32, data bits per row and word width; NumRows, default 4, tile rows per column; ColumnID, default 0, 8-bit column index this instance answers to.
REQ-002 Ports SHALL be, clock and reset first: CLK in 1, single clock; resetn in 1, reset that is asynchronous and active-low.
REQ-003 in_data in FrameBitsPerRow, configuration word.
REQ-004 in_valid in 1, word present.
REQ-005 in_ready out 1, word accepted when in_valid and in_ready are both high on a CLK rising edge.
REQ-006 FrameData out FrameBitsPerRow*NumRows, frame payload; row 0 is the LSB slice.
REQ-007 FrameStrobe out MaxFramesPerCol, one-hot write strobe that drives the column's tile FrameStrobe inputs.
REQ-008 busy out 1, high in any state other than IDLE.
REQ-009 hdr_err out 1, sticky flag for a bad header.
REQ-010 frame_cnt out 16, count of strobes issued.

Function
REQ-011 The state machine SHALL have three states: IDLE, LOAD and STROBE.
REQ-012 Header word fields SHALL be: [31:24] marker 8'hFA, [23:16] column, [4:0] frame index.
REQ-013 In IDLE, an accepted header with a correct marker and frame index < MaxFramesPerCol SHALL latch the column match (column==ColumnID) and the frame index, clear the row counter, and go to LOAD.
REQ-014 In IDLE, an accepted header with a wrong marker or frame index >= MaxFramesPerCol SHALL be discarded, set hdr_err, and leave the block in IDLE.
REQ-015 In LOAD, each accepted word SHALL be written into the row-counter slice of an internal shadow register, and the row counter SHALL increment.
REQ-016 On acceptance of word NumRows-1: if the column matched, the shadow contents plus that word SHALL be copied to FrameData and the block SHALL go to STROBE; otherwise it SHALL return to IDLE and leave FrameData unchanged.
REQ-017 In STROBE, FrameStrobe SHALL assert bit[frame index] only, for exactly one cycle; frame_cnt SHALL increment, wrapping from 16'hFFFF to 0; the next state SHALL be IDLE.
REQ-018 in_ready SHALL be 1 in IDLE and LOAD and 0 in STROBE.
REQ-019 Latency from acceptance of the last data word to FrameStrobe high SHALL be exactly 1 cycle.
REQ-020 FrameData SHALL stay stable from its update through the strobe cycle, and until the next matched frame completes.
REQ-021 FrameStrobe SHALL be registered, glitch-free, and never have more than one bit set.
REQ-022 in_valid low during LOAD SHALL stall the block with no timeout; the row counter SHALL hold.
REQ-023 hdr_err SHALL clear only on reset.

Reset
REQ-024 When resetn is low, the block SHALL reset asynchronously: state=IDLE, FrameStrobe=0, FrameData=0, shadow=0, row counter=0, frame_cnt=0, hdr_err=0, busy=0; in_ready SHALL be 1 once reset is released.
REQ-025 Reset asserted in the middle of LOAD or STROBE SHALL abort the frame with no strobe issued and no partial FrameData update.

Structure
REQ-026 A shared package SHALL hold the state enumeration, the marker constant 8'hFA, and the header field bit positions.
REQ-027 One sub-module, frame_strobe_dec, SHALL be used as the registered index-to-one-hot strobe decoder; everything else SHALL be flat.

Verification
REQ-028 Basic write: ColumnID=0; send header 32'hFA00_0003 then words 1,2,3,4 back-to-back -> FrameData=128'h4_0000_0003_0000_0002_0000_0001 (row 0 LSB), FrameStrobe=20'h00008 for one cycle, 1 cycle after word 4 is accepted, frame_cnt=1.
REQ-029 Other column: header 32'hFA05_0003 at ColumnID=0 with 4 words -> FrameStrobe stays 0, FrameData unchanged, block returns to IDLE.
REQ-030 Bad headers: 32'hAB00_0001 or 32'hFA00_0014 (frame 20) -> hdr_err=1, block stays in IDLE; a following valid frame still completes normally.
REQ-031 Backpressure and stall: in_valid toggling with gaps during LOAD -> correct FrameData; in_ready=0 in the strobe cycle; a word held on in_valid at that time is accepted in the following cycle as a header.
REQ-032 Reset abort: resetn driven low after 2 of 4 data words -> all outputs at reset values, no strobe; a new full frame then completes correctly.
REQ-033 Wrap: frame_cnt preloaded by forcing to 16'hFFFF, one further frame -> frame_cnt=0; frame index 19 -> FrameStrobe=20'h80000.
